mips_bus_lsu: RTL
=================

// Module: mips_bus_lsu
// PURPOSE
//  Two-channel bus load/store unit for the multicycle MIPS core. Arbitrates instruction-fetch
//  and data requests onto one Avalon-MM master, steers byte lanes for byte/half/word(/dword)
//  accesses, sign/zero-extends loads, flags misalignment and bus timeouts.
//  The core FSM issues level requests and waits for a one-cycle ack, so it never touches the bus directly.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width
//  DATA_WIDTH  32  bus width, 32 or 64; NB = DATA_WIDTH/8, OB = log2(NB)
//  TIMEOUT     0   max waitrequest cycles per access; 0 = never time out
//  ARB_MODE    0   0 = data channel has fixed priority, 1 = round-robin
// PORTS
//  clk          in   1           clock, all state on rising edge
//  reset        in   1           asynchronous, active-low reset
//  f_req        in   1           fetch request, held stable until f_ack
//  f_addr       in   ADDR_WIDTH  fetch byte address (full-word access)
//  f_ack        out  1           one-cycle pulse, fetch done
//  f_rdata      out  DATA_WIDTH  fetched word, valid with f_ack
//  f_err        out  1           fetch failed, valid with f_ack
//  d_req        in   1           data request, held stable until d_ack
//  d_we         in   1           1 = store, 0 = load
//  d_size       in   2           log2 bytes: 0 byte, 1 half, 2 word, 3 dword (DATA_WIDTH=64 only)
//  d_signed     in   1           sign-extend load result
//  d_addr       in   ADDR_WIDTH  data byte address
//  d_wdata      in   DATA_WIDTH  store data, right-justified
//  d_ack        out  1           one-cycle pulse, data access done
//  d_rdata      out  DATA_WIDTH  extended load result, valid with d_ack
//  d_err        out  1           misaligned / bad size / timeout, valid with d_ack
//  busy         out  1           state != IDLE
//  address      out  ADDR_WIDTH  Avalon address, low OB bits always 0
//  read, write  out  1           Avalon commands, registered
//  writedata    out  DATA_WIDTH  lane-steered store data
//  byteenable   out  NB          active lanes
//  waitrequest  in   1           slave stall
//  readdata     in   DATA_WIDTH  valid the cycle after read accepted
// BEHAVIOUR
//  Reset (low, async): state IDLE; read, write, acks, errs, busy = 0; address, writedata,
//   byteenable, rdata = 0; RR pointer -> data. Reset mid-access aborts it immediately, no ack.
//  FSM: IDLE -> ISSUE -> (RESP if load/fetch) -> ACK -> IDLE.
//   IDLE: grant on edge when any req. ARB_MODE 0: data wins. ARB_MODE 1: on conflict grant
//    the channel not granted last. Latch addr/size/we/wdata/signed of the winner.
//    Bad request (addr low bits not multiple of 2^size, or 2^size > NB) -> ACK with err=1, no bus cycle.
//   ISSUE: read or write = 1, address = {addr[ADDR_WIDTH-1:OB], OB'b0}, byteenable =
//    ((1<<2^size)-1) << addr[OB-1:0], writedata = wdata << 8*addr[OB-1:0]. Held stable while
//    waitrequest=1. On edge with waitrequest=0: drop command; store -> ACK, load -> RESP.
//    TIMEOUT>0: wait counter clears on entry, increments per waitrequest cycle; when it reaches
//    TIMEOUT drop command -> ACK with err=1.
//   RESP: capture readdata >> 8*addr[OB-1:0], keep low 8*2^size bits, sign- or zero-extend
//    per d_signed. Fetch always full-word, zero-extended.
//   ACK: granted channel's ack = 1 for exactly one cycle with rdata/err; -> IDLE. rdata/err hold
//    until next ack. Load error -> rdata 0.
//  Min latency from req sampled: store 3 cycles, load 4; +1 per waitrequest cycle.
//  Req still high in the IDLE cycle after ack is treated as a new request.
//  Never read and write together; never >1 outstanding access.
// TESTING
//  1 fetch f_addr=BFC00000, waitrequest 2 cycles, readdata=24020005 -> read held 3 cycles,
//    address BFC00000, byteenable 1111, f_ack once, f_rdata=24020005, f_err=0
//  2 load byte d_addr=00001003, readdata=80112233: signed -> byteenable 1000, d_rdata=FFFFFF80;
//    unsigned -> 00000080
//  3 store half d_addr=00001002, d_wdata=0000ABCD -> write=1, address 00001000,
//    byteenable 1100, writedata ABCD0000, d_ack 3 cycles after req
//  4 load half d_addr=00001001 -> read/write never asserted, d_ack with d_err=1, d_rdata=0
//  5 f_req+d_req same cycle: ARB_MODE 0 -> data then fetch; ARB_MODE 1, both held -> grants alternate
//  6 TIMEOUT=4, waitrequest stuck 1 -> read drops after 4 cycles, f_err=1;
//    reset low mid-ISSUE -> read=0 at once, no ack, busy=0

Source files
------------

// File: rtl/mips_bus_lsu_if.sv
// Avalon-MM master-side bus bundle between the LSU and its slave.
// No state; the master drives commands and the slave answers with waitrequest/readdata.
interface mips_bus_lsu_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int NB = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] address;
   logic                  read;
   logic                  write;
   logic [DATA_WIDTH-1:0] writedata;
   logic [NB-1:0]         byteenable;
   logic                  waitrequest;
   logic [DATA_WIDTH-1:0] readdata;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata
   );
endinterface

// File: rtl/mips_bus_lsu.sv
// Fetch/data load-store unit: arbitrates onto one Avalon-MM master, steers lanes, extends loads.
// Latency store 3 / load 4 cycles from request sample (+1 per waitrequest cycle); command held while stalled.
module mips_bus_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 0,
   parameter int ARB_MODE   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  f_req,
   input  logic [ADDR_WIDTH-1:0] f_addr,
   output logic                  f_ack,
   output logic [DATA_WIDTH-1:0] f_rdata,
   output logic                  f_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [1:0]            d_size,
   input  logic                  d_signed,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_ack,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_err,
   output logic                  busy,
   mips_bus_lsu_if.master        av
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int OB = $clog2(NB);
   localparam int TW = $clog2(TIMEOUT + 2);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP, ACK} state_t;

   state_t                state_q, state_d;
   logic                  gnt_data_q, gnt_data_d;
   logic                  prio_data_q, prio_data_d;
   logic [OB-1:0]         off_q, off_d;
   logic [1:0]            size_q, size_d;
   logic                  we_q, we_d;
   logic                  sgn_q, sgn_d;
   logic [TW-1:0]         wcnt_q, wcnt_d;
   logic                  read_q, read_d, write_q, write_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0] writedata_q, writedata_d;
   logic [NB-1:0]         be_q, be_d;
   logic                  f_ack_q, f_ack_d, d_ack_q, d_ack_d;
   logic                  f_err_q, f_err_d, d_err_q, d_err_d;
   logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;

   logic                  sel_data, bad, done, done_err, msb;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [1:0]            w_size;
   logic [DATA_WIDTH-1:0] shifted, ext, done_dat;

   function automatic logic [OB-1:0] align_mask(input logic [1:0] sz);
      logic [OB-1:0] m;
      m = '0;
      for (int i = 0; i < OB; i++) if (i < int'(sz)) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [NB-1:0] lane_en(input logic [1:0] sz, input logic [OB-1:0] off);
      logic [NB-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++)
         if (i >= int'(off) && i < int'(off) + (1 << sz)) m[i] = 1'b1;
      return m;
   endfunction

   // Load alignment: right-justify the addressed lanes, then extend from the top kept bit.
   always_comb begin
      shifted = av.readdata >> (8 * int'(off_q));
      ext     = '0;
      msb     = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (i < (8 << size_q)) begin
            ext[i] = shifted[i];
            msb    = shifted[i];
         end else begin
            ext[i] = sgn_q & msb;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_data_d  = gnt_data_q;
      prio_data_d = prio_data_q;
      off_d       = off_q;
      size_d      = size_q;
      we_d        = we_q;
      sgn_d       = sgn_q;
      wcnt_d      = wcnt_q;
      read_d      = read_q;
      write_d     = write_q;
      address_d   = address_q;
      writedata_d = writedata_q;
      be_d        = be_q;
      f_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      f_err_d     = f_err_q;
      d_err_d     = d_err_q;
      f_rdata_d   = f_rdata_q;
      d_rdata_d   = d_rdata_q;
      done        = 1'b0;
      done_err    = 1'b0;
      done_dat    = '0;

      // prio_data_q names the channel that wins the next conflict in round-robin mode.
      sel_data = d_req && (!f_req || ARB_MODE == 0 || prio_data_q);
      w_addr   = sel_data ? d_addr : f_addr;
      w_size   = sel_data ? d_size : 2'd2;
      bad      = (int'(w_size) > OB) || ((w_addr[OB-1:0] & align_mask(w_size)) != '0);

      case (state_q)
         IDLE: begin
            if (f_req || d_req) begin
               gnt_data_d  = sel_data;
               prio_data_d = !sel_data;
               off_d       = w_addr[OB-1:0];
               size_d      = w_size;
               we_d        = sel_data && d_we;
               sgn_d       = sel_data && d_signed;
               if (bad) begin
                  done     = 1'b1;
                  done_err = 1'b1;
               end else begin
                  state_d     = ISSUE;
                  wcnt_d      = '0;
                  read_d      = !(sel_data && d_we);
                  write_d     = sel_data && d_we;
                  address_d   = {w_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
                  be_d        = lane_en(w_size, w_addr[OB-1:0]);
                  writedata_d = d_wdata << (8 * int'(w_addr[OB-1:0]));
               end
            end
         end
         ISSUE: begin
            if (!av.waitrequest) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               if (we_q) done = 1'b1;
               else      state_d = RESP;
            end else if (TIMEOUT > 0 && int'(wcnt_q) == TIMEOUT - 1) begin
               read_d   = 1'b0;
               write_d  = 1'b0;
               done     = 1'b1;
               done_err = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         RESP: begin
            done     = 1'b1;
            done_dat = ext;
         end
         default: state_d = IDLE;
      endcase

      if (done) begin
         state_d = ACK;
         if (gnt_data_d) begin
            d_ack_d   = 1'b1;
            d_err_d   = done_err;
            d_rdata_d = done_dat;
         end else begin
            f_ack_d   = 1'b1;
            f_err_d   = done_err;
            f_rdata_d = done_dat;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         gnt_data_q  <= 1'b0;
         prio_data_q <= 1'b1;
         off_q       <= '0;
         size_q      <= '0;
         we_q        <= 1'b0;
         sgn_q       <= 1'b0;
         wcnt_q      <= '0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         address_q   <= '0;
         writedata_q <= '0;
         be_q        <= '0;
         f_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         f_err_q     <= 1'b0;
         d_err_q     <= 1'b0;
         f_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         gnt_data_q  <= gnt_data_d;
         prio_data_q <= prio_data_d;
         off_q       <= off_d;
         size_q      <= size_d;
         we_q        <= we_d;
         sgn_q       <= sgn_d;
         wcnt_q      <= wcnt_d;
         read_q      <= read_d;
         write_q     <= write_d;
         address_q   <= address_d;
         writedata_q <= writedata_d;
         be_q        <= be_d;
         f_ack_q     <= f_ack_d;
         d_ack_q     <= d_ack_d;
         f_err_q     <= f_err_d;
         d_err_q     <= d_err_d;
         f_rdata_q   <= f_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign busy          = (state_q != IDLE);
   assign f_ack         = f_ack_q;
   assign f_err         = f_err_q;
   assign f_rdata       = f_rdata_q;
   assign d_ack         = d_ack_q;
   assign d_err         = d_err_q;
   assign d_rdata       = d_rdata_q;
   assign av.read       = read_q;
   assign av.write      = write_q;
   assign av.address    = address_q;
   assign av.writedata  = writedata_q;
   assign av.byteenable = be_q;
endmodule
